// File: rtl/hv_bundler.sv
// hv_bundler -- majority-bundling stage fed by a stream of binary hypervectors.
//
// Accumulates per-dimension population counts over a bundle of up to MAX_N
// hypervectors (closed by in_last or by reaching MAX_N), then resolves each
// dimension by majority. Exact ties take a bit from the tie-break LFSR.
//
// Build option: HV_BUNDLER_TIE_LFSR_EN
//   defined   : serial resolve, one dimension per cycle; ties take tie_bit and
//               pulse tie_en in the same cycle. out_valid appears DIM+1 cycles
//               after the closing input.
//   undefined : all dimensions resolve in parallel at the closing edge; ties
//               resolve to 0, tie_en is held at 0 and tie_bit is ignored.
//
// Ports:
//   clk, nrst             clock, asynchronous active-low reset
//   in_hv/in_valid/in_last/in_ready   input hypervector stream
//   tie_bit / tie_en      LFSR serial bit in, LFSR advance request out
//   out_hv/out_count/out_valid/out_ready   bundled result with handshake
module hv_bundler #(
  parameter int DIM   = 64,
  parameter int MAX_N = 16,
  parameter int CNT_W = $clog2(MAX_N + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [DIM-1:0]   in_hv,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             tie_bit,
  output logic             tie_en,
  output logic [DIM-1:0]   out_hv,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] ST_ACCUM   = 2'd0;
  localparam logic [1:0] ST_RESOLVE = 2'd1;
  localparam logic [1:0] ST_OUTPUT  = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [DIM-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]           n_q, n_d;
  logic [DIM-1:0]             out_hv_q, out_hv_d;
  logic [CNT_W-1:0]           out_count_q, out_count_d;

  logic             accept;
  logic             close_bundle;
  logic             clear_cnt;
  logic [CNT_W-1:0] n_inc;
  logic [DIM-1:0][CNT_W-1:0] cnt_inc;

  assign in_ready     = (state_q == ST_ACCUM);
  assign out_valid    = (state_q == ST_OUTPUT);
  assign out_hv       = out_hv_q;
  assign out_count    = out_count_q;

  assign accept       = in_valid & in_ready;
  assign n_inc        = n_q + CNT_W'(1);
  // in_last and reaching MAX_N on the same input is one close, not two.
  assign close_bundle = accept & (in_last | (n_inc == CNT_W'(MAX_N)));

  // Per-dimension counters. n never exceeds MAX_N, so neither can any counter.
  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_dim
      assign cnt_inc[gi] = cnt_q[gi] + CNT_W'(in_hv[gi]);
      assign cnt_d[gi]   = clear_cnt ? '0 : (accept ? cnt_inc[gi] : cnt_q[gi]);
    end
  endgenerate

`ifdef HV_BUNDLER_TIE_LFSR_EN
  localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W:0]   cur_twice;
  logic [CNT_W:0]   n_ext;
  logic             tie_now;
  logic             res_bit;

  // Comparison is done one bit wider so 2*cnt cannot wrap.
  assign cur_cnt   = cnt_q[idx_q];
  assign cur_twice = {cur_cnt, 1'b0};
  assign n_ext     = {1'b0, n_q};
  assign tie_now   = (state_q == ST_RESOLVE) && (cur_twice == n_ext);
  assign res_bit   = tie_now ? tie_bit : (cur_twice > n_ext);
  assign tie_en    = tie_now;
`else
  logic [DIM-1:0] maj_vec;
  logic           unused_tie;

  assign unused_tie = tie_bit;
  assign tie_en     = 1'b0;

  // Parallel majority over the counts including the closing input; ties -> 0.
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_maj
      assign maj_vec[gi] = {cnt_inc[gi], 1'b0} > {1'b0, n_inc};
    end
  endgenerate
`endif

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    out_hv_d    = out_hv_q;
    out_count_d = out_count_q;
    clear_cnt   = 1'b0;
`ifdef HV_BUNDLER_TIE_LFSR_EN
    idx_d       = idx_q;
`endif
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          n_d = n_inc;
          if (close_bundle) begin
`ifdef HV_BUNDLER_TIE_LFSR_EN
            state_d = ST_RESOLVE;
            idx_d   = '0;
`else
            state_d     = ST_OUTPUT;
            out_hv_d    = maj_vec;
            out_count_d = n_inc;
`endif
          end
        end
      end
`ifdef HV_BUNDLER_TIE_LFSR_EN
      ST_RESOLVE: begin
        out_hv_d[idx_q] = res_bit;
        if (idx_q == IDX_W'(DIM - 1)) begin
          state_d     = ST_OUTPUT;
          out_count_d = n_q;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
`endif
      ST_OUTPUT: begin
        if (out_ready) begin
          state_d   = ST_ACCUM;
          n_d       = '0;
          clear_cnt = 1'b1;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_ACCUM;
      cnt_q       <= '0;
      n_q         <= '0;
      out_hv_q    <= '0;
      out_count_q <= '0;
`ifdef HV_BUNDLER_TIE_LFSR_EN
      idx_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      out_hv_q    <= out_hv_d;
      out_count_q <= out_count_d;
`ifdef HV_BUNDLER_TIE_LFSR_EN
      idx_q       <= idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_hv_bundler.sv
// Self-checking bench for hv_bundler (DIM=8, MAX_N=4). Expected values follow
// the build option: with HV_BUNDLER_TIE_LFSR_EN ties take the supplied LFSR
// bits and results appear DIM+1 cycles after the closing input; without it
// ties resolve to 0 and results appear one cycle after the closing input.
module tb_hv_bundler;
  localparam int DIM   = 8;
  localparam int MAX_N = 4;
  localparam int CNT_W = $clog2(MAX_N + 1);
`ifdef HV_BUNDLER_TIE_LFSR_EN
  localparam int EXP_LAT = DIM + 1;
  localparam bit TIES_ON = 1'b1;
`else
  localparam int EXP_LAT = 1;
  localparam bit TIES_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic [DIM-1:0]   in_hv = '0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             tie_bit = 1'b0;
  logic             tie_en;
  logic [DIM-1:0]   out_hv;
  logic [CNT_W-1:0] out_count;
  logic             out_valid;
  logic             out_ready = 1'b0;

  always #5 clk = ~clk;

  hv_bundler #(.DIM(DIM), .MAX_N(MAX_N), .CNT_W(CNT_W)) dut (
    .clk(clk), .nrst(nrst),
    .in_hv(in_hv), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .tie_bit(tie_bit), .tie_en(tie_en),
    .out_hv(out_hv), .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic [3:0][7:0] hv;       // hv[k] is the k-th input
    int              n;
    logic            last;     // in_last on the final input
    logic [7:0]      ties;     // ties[k] is the LFSR bit for the k-th tie
    logic [7:0]      exp_hv;
    int              exp_ties;
  } vec_t;

  vec_t vecs[6];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drives v's inputs; returns #1 after the edge that accepted the last one.
  task automatic send(input vec_t v, input logic pre_ready);
    int cyc;
    out_ready = pre_ready;
    for (int k = 0; k < v.n; k++) begin
      in_hv    = v.hv[k];
      in_valid = 1'b1;
      in_last  = (k == v.n - 1) ? v.last : 1'b0;
      cyc = 0;
      while (!in_ready && cyc < 50) begin
        @(posedge clk); #1; cyc++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
  endtask

  // Waits for out_valid, feeding LFSR bits on tie cycles, then checks results.
  task automatic await_result(input vec_t v, input int id);
    int lat;
    int ties;
    lat  = 1;
    ties = 0;
    check($sformatf("v%0d_in_ready_after_close", id), 32'(in_ready), 32'd0);
    while (!out_valid && lat < 40) begin
      if (tie_en) begin
        tie_bit = (ties < 8) ? v.ties[ties] : 1'b0;
        ties++;
      end
      @(posedge clk); #1; lat++;
    end
    if (tie_en) ties++;
    $display("bundle %0d: out_hv=%02h out_count=%0d ties=%0d latency=%0d",
             id, out_hv, out_count, ties, lat);
    check($sformatf("v%0d_latency", id), 32'(lat), 32'(EXP_LAT));
    check($sformatf("v%0d_out_hv", id), 32'(out_hv), 32'(v.exp_hv));
    check($sformatf("v%0d_out_count", id), 32'(out_count), 32'(v.n));
    check($sformatf("v%0d_tie_cycles", id), 32'(ties), 32'(v.exp_ties));
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{hv: {8'h00, 8'hAA, 8'hCC, 8'hF0}, n: 3, last: 1'b1, ties: 8'h00,
                exp_hv: 8'hE8, exp_ties: 0};
    vecs[1] = '{hv: {8'h00, 8'h00, 8'h0F, 8'hFF}, n: 2, last: 1'b1, ties: 8'b0000_1101,
                exp_hv: TIES_ON ? 8'hDF : 8'h0F, exp_ties: TIES_ON ? 4 : 0};
    vecs[2] = '{hv: {8'h01, 8'h01, 8'h01, 8'h01}, n: 4, last: 1'b0, ties: 8'h00,
                exp_hv: 8'h01, exp_ties: 0};
    vecs[3] = '{hv: {8'h00, 8'hFF, 8'h3C, 8'hC3}, n: 4, last: 1'b1, ties: 8'hB9,
                exp_hv: TIES_ON ? 8'hB9 : 8'h00, exp_ties: TIES_ON ? 8 : 0};
    vecs[4] = '{hv: {8'h00, 8'h00, 8'h00, 8'hA5}, n: 1, last: 1'b1, ties: 8'h00,
                exp_hv: 8'hA5, exp_ties: 0};
    vecs[5] = '{hv: {8'h00, 8'h7E, 8'h81, 8'h81}, n: 3, last: 1'b1, ties: 8'h00,
                exp_hv: 8'h81, exp_ties: 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_hv", 32'(out_hv), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_tie_en", 32'(tie_en), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven bundles; vector 1 also has out_ready high before out_valid
    for (int i = 0; i < 6; i++) begin
      send(vecs[i], (i == 1));
      await_result(vecs[i], i);
      handshake($sformatf("v%0d_hs", i));
    end

    // Backpressure: hold result for 5 cycles while upstream pushes junk
    send(vecs[1], 1'b0);
    await_result(vecs[1], 10);
    in_hv = 8'hFF; in_valid = 1'b1; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_out_hv", c), 32'(out_hv), 32'(vecs[1].exp_hv));
      check($sformatf("bp%0d_out_count", c), 32'(out_count), 32'd2);
      check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    handshake("bp_hs");
    v = '{hv: {8'h00, 8'h00, 8'h00, 8'h5A}, n: 1, last: 1'b1, ties: 8'h00,
          exp_hv: 8'h5A, exp_ties: 0};
    send(v, 1'b0);
    await_result(v, 11);
    handshake("bp2_hs");

    // Reset mid-bundle: during idx 3 of resolve (or in OUTPUT when resolve is parallel)
    v = '{hv: {8'h00, 8'h00, 8'hFF, 8'hFF}, n: 2, last: 1'b1, ties: 8'h00,
          exp_hv: 8'hFF, exp_ties: 0};
    send(v, 1'b0);
    for (int c = 1; c < (TIES_ON ? 4 : 1); c++) begin
      @(posedge clk); #1;
    end
    nrst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_hv", 32'(out_hv), 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_out_hv", 32'(out_hv), 32'd0);
    check("post_rst_out_count", 32'(out_count), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_tie_en", 32'(tie_en), 32'd0);
    v = '{hv: {8'h00, 8'h00, 8'h00, 8'h3C}, n: 1, last: 1'b1, ties: 8'h00,
          exp_hv: 8'h3C, exp_ties: 0};
    send(v, 1'b0);
    await_result(v, 12);
    handshake("post_rst_hs");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
